vend_buyer_ctrl: RTL and testbench
==================================

Name: vend_buyer_ctrl

Overview:
- Buyer-side controller for the coin/cola/refund vending interface; drives `coin` and `refund_request` into the vending FSM and consumes its `cola` and `refund` outputs.
- On a purchase command it inserts COIN_PRICE coins as spaced single-cycle pulses, then waits for `cola`.
- A cancel issued after the first coin requests a refund.
- Each transaction ends with exactly one of three result pulses: `cola_done`, `refund_done`, or `err`.

Parameters:
- COIN_PRICE, 3, coins required for one cola; legal range 2..7.
- COIN_GAP, 2, idle cycles between consecutive coin pulses; legal range 1..255.
- TIMEOUT, 8, maximum cycles to wait for `cola` or `refund`; legal range 2..255.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous active-low reset
- buy_req  in  1  start purchase; sampled in IDLE only
- cancel  in  1  abort request; acted on only when exactly one coin has been inserted
- cola  in  1  vendor cola pulse
- refund  in  1  vendor refund pulse
- coin  out  1  single-cycle coin pulse to vendor
- refund_request  out  1  single-cycle refund request to vendor
- busy  out  1  transaction in progress
- cola_done  out  1  one-cycle pulse: cola received
- refund_done  out  1  one-cycle pulse: refund received
- err  out  1  one-cycle pulse: timeout
- cola_cnt  out  8  colas received since reset; wraps 255->0

Behaviour:
- Reset: sys_clk/sys_rst_n as decided. On reset all outputs are 0, state is IDLE, and all counters are 0. Reset mid-transaction aborts immediately with no result pulse.
- All outputs are registered.
- States: IDLE, COIN, GAP, WAIT_COLA, REQ_REF, WAIT_REF.
- busy = 1 in every state except IDLE.
- IDLE:
  - buy_req=1 -> COIN; coins_issued cleared.
  - cancel in IDLE is ignored.
  - buy_req in any other state is ignored.
- COIN:
  - coin=1 for this cycle only; coins_issued increments.
  - If coins_issued (new value) == COIN_PRICE -> WAIT_COLA, else -> GAP; gap counter cleared.
- GAP:
  - coin=0 for COIN_GAP cycles, then -> COIN.
  - cancel=1 sampled in any GAP cycle while coins_issued==1 -> REQ_REF; this takes priority over the gap expiring.
  - cancel while coins_issued>=2 is ignored; the purchase completes.
- REQ_REF: refund_request=1 for this cycle only -> WAIT_REF; timeout counter cleared.
- `coin` and `refund_request` are never asserted in the same cycle.
- WAIT_COLA:
  - Timeout counter increments each cycle.
  - cola=1 sampled -> IDLE, with cola_done=1 in the first IDLE cycle and cola_cnt+1.
  - Counter reaches TIMEOUT with no cola -> IDLE, with err=1.
  - If cola and timeout occur on the same cycle, cola wins.
- WAIT_REF: same as WAIT_COLA, but watches `refund` and produces refund_done. refund_done does not change cola_cnt.
- Spurious `cola`/`refund` while in IDLE, COIN or GAP is ignored; no pulse, no count.
- Result pulses: exactly one of cola_done/refund_done/err per transaction, coincident with busy falling.
- Back-to-back: buy_req high in the same IDLE cycle as a result pulse starts the next transaction.
- Latency with defaults: buy_req sampled at edge 0 -> coin high in cycles 1, 4, 7. Vendor cola in cycle 8 -> cola_done in cycle 9, busy high in cycles 1..8.

Test Plan:
- Normal purchase (defaults, reference vending model attached): buy_req pulse at cycle 0 -> coin pulses at cycles 1/4/7, cola at 8, cola_done at 9, cola_cnt=1, busy cycles 1..8.
- Cancel after first coin: buy_req at 0, cancel at cycle 2 -> refund_request at cycle 3, vendor refund at 4, refund_done at 5, no further coin, cola_cnt unchanged.
- Late cancel: cancel asserted at cycle 5 (after the second coin) -> ignored; normal completion, cola_done at 9.
- Timeout: vendor model disconnected (cola held 0) -> 3 coins issued, err pulse 8 cycles after entering WAIT_COLA, busy drops, cola_cnt unchanged.
- Reset and protocol robustness:
  - sys_rst_n low at cycle 5 mid-purchase -> all outputs 0 immediately, no result pulse, next buy_req restarts at coin 1.
  - buy_req pulses while busy -> ignored.
  - cola pulse injected in IDLE -> no effect.
- Counter wrap and back-to-back: 256 back-to-back purchases with buy_req held high -> cola_cnt returns to 0, 256 cola_done pulses, never coin and refund_request in the same cycle.

Source files
------------

// File: rtl/vend_buyer_ctrl.sv
// Buyer-side controller for the coin/cola/refund vending handshake.
// Inserts spaced coin pulses, optionally requests a refund, and reports one result per transaction.
module vend_buyer_ctrl #(
    parameter int COIN_PRICE = 3,
    parameter int COIN_GAP   = 2,
    parameter int TIMEOUT    = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       buy_req,
    input  logic       cancel,
    input  logic       cola,
    input  logic       refund,
    output logic       coin,
    output logic       refund_request,
    output logic       busy,
    output logic       cola_done,
    output logic       refund_done,
    output logic       err,
    output logic [7:0] cola_cnt
);

    localparam logic [2:0] PRICE    = 3'(COIN_PRICE);
    localparam logic [7:0] GAP_LAST = 8'(COIN_GAP - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        WAIT_COLA,
        REQ_REF,
        WAIT_REF
    } state_t;

    state_t     state_q;
    logic [2:0] coins_q;
    logic [2:0] coins_d;
    logic [7:0] gap_q;
    logic [7:0] tmo_q;
    logic [7:0] cola_cnt_q;
    logic [7:0] cola_cnt_d;
    logic       coin_q;
    logic       refund_request_q;
    logic       busy_q;
    logic       cola_done_q;
    logic       refund_done_q;
    logic       err_q;

    assign coins_d    = coins_q + 3'd1;
    assign cola_cnt_d = cola_cnt_q + 8'd1;

    // Pulse outputs default low every cycle and are raised on the transition into the state they mark.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= IDLE;
            coins_q          <= 3'd0;
            gap_q            <= 8'd0;
            tmo_q            <= 8'd0;
            cola_cnt_q       <= 8'd0;
            coin_q           <= 1'b0;
            refund_request_q <= 1'b0;
            busy_q           <= 1'b0;
            cola_done_q      <= 1'b0;
            refund_done_q    <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            coin_q           <= 1'b0;
            refund_request_q <= 1'b0;
            cola_done_q      <= 1'b0;
            refund_done_q    <= 1'b0;
            err_q            <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (buy_req) begin
                        state_q <= COIN;
                        coins_q <= 3'd0;
                        coin_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                COIN: begin
                    coins_q <= coins_d;
                    gap_q   <= 8'd0;
                    if (coins_d == PRICE) begin
                        state_q <= WAIT_COLA;
                        tmo_q   <= 8'd0;
                    end else begin
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    // A cancel only counts while a single coin is in; it beats the gap expiring.
                    if (cancel && coins_q == 3'd1) begin
                        state_q          <= REQ_REF;
                        refund_request_q <= 1'b1;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= COIN;
                        coin_q  <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                REQ_REF: begin
                    state_q <= WAIT_REF;
                    tmo_q   <= 8'd0;
                end
                WAIT_COLA: begin
                    if (cola) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cola_done_q <= 1'b1;
                        cola_cnt_q  <= cola_cnt_d;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                WAIT_REF: begin
                    if (refund) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        refund_done_q <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin           = coin_q;
    assign refund_request = refund_request_q;
    assign busy           = busy_q;
    assign cola_done      = cola_done_q;
    assign refund_done    = refund_done_q;
    assign err            = err_q;
    assign cola_cnt       = cola_cnt_q;

endmodule

// File: tb/tb_vend_buyer_ctrl.sv
// Self-checking bench for vend_buyer_ctrl: a vending-machine model answers the buyer,
// and expected coin/refund/result events are queued and matched as the DUT emits them.
module tb_vend_buyer_ctrl;

    localparam int PRICE      = 3;
    localparam int GAP        = 2;
    localparam int TMO        = 8;
    localparam int WAIT_START = 1 + (PRICE - 1) * (GAP + 1) + 1;
    localparam int K_COLA     = 1;
    localparam int K_REFUND   = 2;
    localparam int K_ERR      = 3;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } expResult_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       buy_req;
    logic       cancel;
    logic       cola;
    logic       refund;
    logic       coin;
    logic       refund_request;
    logic       busy;
    logic       cola_done;
    logic       refund_done;
    logic       err;
    logic [7:0] cola_cnt;

    logic       vendCola;
    logic       vendRefund;
    logic       injCola;
    logic       pendCola;
    logic       pendRef;
    bit         vendorOn;
    int         vendCoins;

    int         cycle;
    int         checks;
    int         errors;
    int         expCnt;
    int         colaSeen;

    int         coinQ[$];
    int         refQ[$];
    expResult_t resQ[$];

    assign cola   = vendCola | injCola;
    assign refund = vendRefund;

    vend_buyer_ctrl #(
        .COIN_PRICE(PRICE),
        .COIN_GAP  (GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .buy_req       (buy_req),
        .cancel        (cancel),
        .cola          (cola),
        .refund        (refund),
        .coin          (coin),
        .refund_request(refund_request),
        .busy          (busy),
        .cola_done     (cola_done),
        .refund_done   (refund_done),
        .err           (err),
        .cola_cnt      (cola_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cycle = 0;
    always @(posedge sys_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Vending model: answers one cycle after the last coin or after a refund request.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            vendCoins  = 0;
            pendCola   = 1'b0;
            pendRef    = 1'b0;
            vendCola   = 1'b0;
            vendRefund = 1'b0;
        end else begin
            vendCola   = pendCola;
            vendRefund = pendRef;
            pendCola   = 1'b0;
            pendRef    = 1'b0;
            if (vendorOn && coin) begin
                vendCoins++;
                if (vendCoins == PRICE) begin
                    pendCola  = 1'b1;
                    vendCoins = 0;
                end
            end
            if (vendorOn && refund_request) begin
                pendRef   = 1'b1;
                vendCoins = 0;
            end
        end
    end

    // Scoreboard side: every pulse the DUT emits must match the head of its queue.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (coin || refund_request)
                checkOutput("coinRefExclusive", int'(coin & refund_request), 0);
            if (coin) begin
                if (coinQ.size() == 0) checkOutput("coinUnexpected", cycle, -1);
                else                   checkOutput("coinCycle", cycle, coinQ.pop_front());
            end
            if (refund_request) begin
                if (refQ.size() == 0) checkOutput("refReqUnexpected", cycle, -1);
                else                  checkOutput("refReqCycle", cycle, refQ.pop_front());
            end
            if (cola_done || refund_done || err) begin
                int obsKind;
                expResult_t e;
                if (cola_done) colaSeen++;
                obsKind = cola_done ? K_COLA : (refund_done ? K_REFUND : K_ERR);
                checkOutput("resultOnehot", int'(cola_done) + int'(refund_done) + int'(err), 1);
                checkOutput("busyAtResult", int'(busy), 0);
                if (resQ.size() == 0) begin
                    checkOutput("resultUnexpected", cycle, -1);
                end else begin
                    e = resQ.pop_front();
                    checkOutput("resultKind", obsKind, e.kind);
                    checkOutput("resultCycle", cycle, e.cyc);
                    checkOutput("colaCnt", int'(cola_cnt), e.cnt);
                end
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".coin"}, int'(coin), 0);
        checkOutput({tag, ".refReq"}, int'(refund_request), 0);
        checkOutput({tag, ".busy"}, int'(busy), 0);
        checkOutput({tag, ".colaDone"}, int'(cola_done), 0);
        checkOutput({tag, ".refundDone"}, int'(refund_done), 0);
        checkOutput({tag, ".err"}, int'(err), 0);
        checkOutput({tag, ".colaCnt"}, int'(cola_cnt), expCnt);
    endtask

    task automatic drainCheck(input string tag);
        checkOutput({tag, ".coinQ"}, coinQ.size(), 0);
        checkOutput({tag, ".refQ"}, refQ.size(), 0);
        checkOutput({tag, ".resQ"}, resQ.size(), 0);
    endtask

    task automatic doReset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        expCnt    = 0;
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // One transaction: queue its expected events, then drive inputs by cycle offset from buy_req.
    task automatic applyStimulus(input string tag, input int kind, input int cancelAt,
                                 input int colaAt, input bit busyBuys, input bit vendor);
        int base;
        int resRel;
        expResult_t e;
        vendorOn = vendor;
        @(negedge sys_clk);
        base = cycle;
        if (kind == K_REFUND) begin
            coinQ.push_back(base + 1);
            refQ.push_back(base + cancelAt + 1);
            resRel = cancelAt + 3;
        end else begin
            for (int i = 0; i < PRICE; i++) coinQ.push_back(base + 1 + i * (GAP + 1));
            if (kind == K_ERR)   resRel = WAIT_START + TMO;
            else if (colaAt >= 0) resRel = colaAt + 1;
            else                 resRel = WAIT_START + 1;
        end
        if (kind == K_COLA) expCnt = (expCnt + 1) & 255;
        e.kind = kind;
        e.cyc  = base + resRel;
        e.cnt  = expCnt;
        resQ.push_back(e);
        for (int rel = 0; rel < 40; rel++) begin
            if (rel > 0) @(negedge sys_clk);
            checkOutput({tag, ".busy"}, int'(busy), int'(rel >= 1 && rel < resRel));
            buy_req = (rel == 0) || (busyBuys && (rel == 3 || rel == 8));
            cancel  = (rel == cancelAt);
            injCola = (rel == colaAt);
        end
        buy_req = 1'b0;
        cancel  = 1'b0;
        injCola = 1'b0;
        drainCheck(tag);
    endtask

    initial begin
        int base;
        int seenBefore;
        expResult_t e;
        checks    = 0;
        errors    = 0;
        expCnt    = 0;
        colaSeen  = 0;
        vendorOn  = 1'b1;
        buy_req   = 1'b0;
        cancel    = 1'b0;
        injCola   = 1'b0;
        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1;
        checkIdleOutputs("por");
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        applyStimulus("normal", K_COLA, -1, -1, 1'b1, 1'b1);
        applyStimulus("cancel", K_REFUND, 2, -1, 1'b0, 1'b1);
        applyStimulus("lateCancel", K_COLA, 5, -1, 1'b0, 1'b1);
        applyStimulus("timeout", K_ERR, -1, -1, 1'b0, 1'b0);
        applyStimulus("colaTie", K_COLA, -1, WAIT_START + TMO - 1, 1'b0, 1'b0);

        // Spurious cola and cancel while idle must leave everything untouched.
        vendorOn = 1'b1;
        @(negedge sys_clk);
        injCola = 1'b1;
        cancel  = 1'b1;
        @(negedge sys_clk);
        injCola = 1'b0;
        cancel  = 1'b0;
        repeat (10) @(negedge sys_clk);
        checkIdleOutputs("idleSpurious");

        // Reset in the gap after the second coin aborts with no result.
        @(negedge sys_clk);
        base = cycle;
        coinQ.push_back(base + 1);
        coinQ.push_back(base + 1 + GAP + 1);
        buy_req = 1'b1;
        @(negedge sys_clk);
        buy_req = 1'b0;
        while (cycle < base + 5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        expCnt    = 0;
        #1;
        checkIdleOutputs("midReset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (15) @(negedge sys_clk);
        drainCheck("midReset");
        applyStimulus("afterReset", K_COLA, -1, -1, 1'b0, 1'b1);

        // 256 back-to-back purchases with buy_req held high wrap the cola counter.
        doReset();
        vendorOn = 1'b1;
        seenBefore = colaSeen;
        @(negedge sys_clk);
        base = cycle;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < PRICE; i++) coinQ.push_back(base + 9 * n + 1 + i * (GAP + 1));
            e.kind = K_COLA;
            e.cyc  = base + 9 * n + 9;
            e.cnt  = (n + 1) & 255;
            resQ.push_back(e);
        end
        buy_req = 1'b1;
        while (cycle < base + 9 * 256) @(negedge sys_clk);
        buy_req = 1'b0;
        repeat (12) @(negedge sys_clk);
        drainCheck("wrap");
        checkOutput("wrapColaCnt", int'(cola_cnt), 0);
        checkOutput("wrapColaDones", colaSeen - seenBefore, 256);
        checkOutput("wrapBusy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
